// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

    localparam logic [5:0]  OP_HALT   = 6'h3F;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    typedef enum logic {
        RUN,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO; entry 0 is the head, empty slots read as zero.
module fetch_queue
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      flush_i,
    input  logic      push_i,
    input  fq_entry_t din_i,
    input  logic      pop_i,
    output fq_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    logic [1:0] cnt_q, cnt_d;
    fq_entry_t  e0_q, e0_d;
    fq_entry_t  e1_q, e1_d;

    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        if (flush_i) begin
            cnt_d = 2'd0;
            e0_d  = '0;
            e1_d  = '0;
        end else if (push_i && pop_i) begin
            // Occupancy is unchanged; the tail slides down when two deep.
            if (cnt_q == 2'd2) begin
                e0_d = e1_q;
                e1_d = din_i;
            end else begin
                e0_d = din_i;
            end
        end else if (pop_i) begin
            e0_d  = e1_q;
            e1_d  = '0;
            cnt_d = cnt_q - 2'd1;
        end else if (push_i) begin
            if (cnt_q == 2'd0) begin
                e0_d = din_i;
            end else begin
                e1_d = din_i;
            end
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign head_o  = e0_q;
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: PC, halt FSM and redirect handling.
module ifetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IM_BYTES  = 1024,
    parameter logic [31:0] HALT_WORD = mips_pkg::HALT_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    input  logic [31:0] im_ir,
    output logic [31:0] im_pc,
    output logic        im_off,
    output logic        id_valid,
    output logic [31:0] id_ir,
    output logic [31:0] id_pc,
    output logic        halted
);

    localparam logic [31:0] LAST_PC = 32'(IM_BYTES - 4);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic         fetch, pop, full, empty;
    logic [31:0]  word, target;
    fq_entry_t    din, head;

    assign pop    = id_valid & id_ready;
    assign fetch  = ~rst & (state_q == RUN) & ~redirect & (~full | pop);
    assign target = redirect_pc & ~32'h3;
    // Beyond the end of memory the im output is garbage; synthesize a halt.
    assign word   = (pc_q <= LAST_PC) ? im_ir : HALT_WORD;
    assign din    = '{pc: pc_q, ir: word};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else if (redirect) begin
            state_q <= RUN;
            pc_q    <= target;
        end else if (fetch) begin
            if (word[31:26] == OP_HALT) begin
                state_q <= HALT;
            end else begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    fetch_queue u_queue (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (fetch),
        .din_i   (din),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign im_pc    = pc_q;
    assign im_off   = ~fetch;
    assign id_valid = ~empty;
    assign id_ir    = head.ir;
    assign id_pc    = head.pc;
    assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: a 1 KiB image and a 16-byte image.
module tb_ifetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, redirect, id_ready;
    logic [31:0] redirect_pc;
    logic [31:0] a_ir, a_pc, a_idir, a_idpc;
    logic        a_off, a_val, a_halt;
    logic [31:0] b_ir, b_pc, b_idir, b_idpc;
    logic        b_off, b_val, b_halt;

    int n_run  = 0;
    int n_fail = 0;

    // Image A: ADD-type words tagged by word index, halt at 0xC.
    always_comb begin
        if (a_pc[9:2] == 8'd3) a_ir = 32'hFC00_0000;
        else a_ir = 32'h0000_0020 | {8'h00, a_pc[9:2], 16'h0000};
    end

    // Image B: 16 bytes, no halt; beyond the end returns junk.
    always_comb begin
        if (b_pc < 32'd16) b_ir = 32'h0000_1000 + b_pc;
        else b_ir = 32'hDEAD_BEEF;
    end

    ifetch_ctrl #(.RESET_PC(32'h0), .IM_BYTES(1024)) dut_a (
        .clk(clk), .rst(rst), .redirect(redirect),
        .redirect_pc(redirect_pc), .id_ready(id_ready),
        .im_ir(a_ir), .im_pc(a_pc), .im_off(a_off),
        .id_valid(a_val), .id_ir(a_idir), .id_pc(a_idpc),
        .halted(a_halt)
    );

    ifetch_ctrl #(.RESET_PC(32'h0), .IM_BYTES(16)) dut_b (
        .clk(clk), .rst(rst), .redirect(1'b0),
        .redirect_pc(32'h0), .id_ready(1'b1),
        .im_ir(b_ir), .im_pc(b_pc), .im_off(b_off),
        .id_valid(b_val), .id_ir(b_idir), .id_pc(b_idpc),
        .halted(b_halt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        #2;
        chk("rst_off_comb", 32'(a_off), 32'd1);
        tick();
        chk("rst_valid", 32'(a_val), 32'd0);
        chk("rst_halted", 32'(a_halt), 32'd0);
        chk("rst_impc", a_pc, 32'h0);
        chk("rst_idir", a_idir, 32'h0);
        rst = 1'b0;
        #1;
        chk("run_off", 32'(a_off), 32'd0);

        // Straight-line stream 0,4,8,C then halt
        tick();
        chk("s_valid0", 32'(a_val), 32'd1);
        chk("s_pc0", a_idpc, 32'h0);
        chk("s_ir0", a_idir, 32'h0000_0020);
        chk("b_pc0", b_idpc, 32'h0);
        tick();
        chk("s_pc4", a_idpc, 32'h4);
        tick();
        chk("s_pc8", a_idpc, 32'h8);
        chk("s_ir8", a_idir, 32'h0002_0020);
        chk("b_pc8", b_idpc, 32'h8);
        tick();
        chk("s_pcC", a_idpc, 32'hC);
        chk("s_irC", a_idir, 32'hFC00_0000);
        chk("s_haltC", 32'(a_halt), 32'd1);
        chk("s_offC", 32'(a_off), 32'd1);
        chk("s_impcC", a_pc, 32'hC);
        chk("b_pcC", b_idpc, 32'hC);
        chk("b_halt_early", 32'(b_halt), 32'd0);
        tick();
        chk("s_drain", 32'(a_val), 32'd0);
        chk("s_off_hold", 32'(a_off), 32'd1);
        chk("b_pc10", b_idpc, 32'h10);
        chk("b_ir10", b_idir, 32'hFC00_0000);
        chk("b_halt", 32'(b_halt), 32'd1);
        tick();
        chk("b_drain", 32'(b_val), 32'd0);
        chk("b_off", 32'(b_off), 32'd1);

        // Redirect out of HALT
        redirect = 1'b1; redirect_pc = 32'h8;
        #1;
        chk("rd_off_comb", 32'(a_off), 32'd1);
        tick();
        redirect = 1'b0;
        chk("rh_halted", 32'(a_halt), 32'd0);
        chk("rh_valid", 32'(a_val), 32'd0);
        chk("rh_impc", a_pc, 32'h8);
        tick();
        chk("rh_pc8", a_idpc, 32'h8);
        chk("rh_ir8", a_idir, 32'h0002_0020);

        // Backpressure: queue fills with 0,4 and pc holds at 8
        rst = 1'b1;
        tick();
        rst = 1'b0; id_ready = 1'b0;
        chk("r2_valid", 32'(a_val), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("bp_pc0", a_idpc, 32'h0);
        chk("bp_impc", a_pc, 32'h8);
        chk("bp_off", 32'(a_off), 32'd1);
        id_ready = 1'b1;
        #1;
        chk("bp_pop_off", 32'(a_off), 32'd0);
        tick();
        chk("bp_pc4", a_idpc, 32'h4);
        tick();
        chk("bp_pc8", a_idpc, 32'h8);
        chk("bp_haltC", 32'(a_halt), 32'd1);

        // Redirect with full queue and ready high
        redirect = 1'b1; redirect_pc = 32'h43;
        tick();
        redirect = 1'b0;
        chk("fr_valid", 32'(a_val), 32'd0);
        chk("fr_impc", a_pc, 32'h40);
        chk("fr_halted", 32'(a_halt), 32'd0);
        tick();
        chk("fr_pc40", a_idpc, 32'h40);
        chk("fr_ir40", a_idir, 32'h0010_0020);
        tick();
        chk("fr_pc44", a_idpc, 32'h44);

        // Reset beats a simultaneous redirect
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        #1;
        chk("rr_off", 32'(a_off), 32'd1);
        tick();
        rst = 1'b0; redirect = 1'b0;
        chk("rr_valid", 32'(a_val), 32'd0);
        chk("rr_impc", a_pc, 32'h0);
        chk("rr_halted", 32'(a_halt), 32'd0);
        tick();
        chk("rr_pc0", a_idpc, 32'h0);
        chk("rr_val1", 32'(a_val), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
